// File: rtl/ocm_avmm_pkg.sv
// ---------------------------------------------------------------------------
// ocm_avmm_pkg
// Shared constants, the lane type and lane helpers for the 32-bit to 128-bit
// Avalon-MM width adapter.
//   S_DW   : narrow (slave-side) data width
//   M_DW   : wide (master-side, OCM) data width
//   LANES  : number of narrow words in one wide beat
//   lane_t : index of a 32-bit word within a 128-bit beat (address bits [3:2])
// ---------------------------------------------------------------------------
package ocm_avmm_pkg;

   localparam int S_DW  = 32;
   localparam int M_DW  = 128;
   localparam int LANES = M_DW / S_DW;

   typedef logic [1:0] lane_t;

   // Extract the 32-bit word of a 128-bit beat that belongs to a lane.
   function automatic logic [S_DW-1:0] lane_select(input logic [M_DW-1:0] data,
                                                   input lane_t           lane);
      return data[{lane, 5'b0} +: S_DW];
   endfunction

   // Move the 4 narrow byte enables onto the byte lanes of the wide beat.
   function automatic logic [M_DW/8-1:0] be_shift(input logic [S_DW/8-1:0] be,
                                                  input lane_t             lane);
      return (M_DW/8)'(be) << {lane, 2'b00};
   endfunction

endpackage

// File: rtl/ocm_lane_fifo.sv
// ---------------------------------------------------------------------------
// ocm_lane_fifo
// Synchronous FIFO of lane indices, one entry per outstanding read. Its
// occupancy is the adapter's pending-read count. The head entry is visible
// combinationally so that a return beat can be narrowed in the cycle it pops.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_lane   : enqueue a lane (ignored while full)
//   pop               : dequeue the head (ignored while empty)
//   pop_lane          : current head entry
//   full, empty       : occupancy flags
// ---------------------------------------------------------------------------
module ocm_lane_fifo
   import ocm_avmm_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  lane_t push_lane,
   input  logic  pop,
   output lane_t pop_lane,
   output logic  full,
   output logic  empty
);

   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

   lane_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_lane = mem[rd_ptr];

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_lane;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ocm_avmm_width_adapter.sv
// ---------------------------------------------------------------------------
// ocm_avmm_width_adapter
// Bridges a 32-bit Avalon-MM master onto a 128-bit pipeline-bridge slave.
// Each narrow read/write becomes one wide access: write data is replicated
// into all four lanes and the byte enables are steered to lane addr[3:2].
// The lane of every accepted read is queued so the in-order 128-bit returns
// can be narrowed back to the requested 32-bit word.
// Ports:
//   clk_clk, reset_reset_n         : clock, asynchronous active-low reset
//   s_address/s_read/s_write/
//   s_writedata/s_byteenable       : narrow command in
//   s_waitrequest                  : narrow stall (combinational)
//   s_readdata/s_readdatavalid     : narrow read return
//   m_address/m_read/m_write/
//   m_writedata/m_byteenable       : wide command out (registered, 1 clk)
//   m_burstcount/m_debugaccess     : constant 1 / 0
//   m_waitrequest                  : wide stall in
//   m_readdata/m_readdatavalid     : wide read return in
//   addr_err                       : sticky, address above OCM_AW bits seen
//   proto_err                      : sticky, return with no read pending
// ---------------------------------------------------------------------------
module ocm_avmm_width_adapter
   import ocm_avmm_pkg::*;
#(
   parameter int MAX_PENDING = 8,
   parameter int OCM_AW      = 18
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [31:0]         s_address,
   input  logic                s_read,
   input  logic                s_write,
   input  logic [S_DW-1:0]     s_writedata,
   input  logic [S_DW/8-1:0]   s_byteenable,
   output logic                s_waitrequest,
   output logic [S_DW-1:0]     s_readdata,
   output logic                s_readdatavalid,
   output logic [OCM_AW-1:0]   m_address,
   output logic                m_read,
   output logic                m_write,
   output logic [M_DW-1:0]     m_writedata,
   output logic [M_DW/8-1:0]   m_byteenable,
   output logic                m_burstcount,
   output logic                m_debugaccess,
   input  logic                m_waitrequest,
   input  logic [M_DW-1:0]     m_readdata,
   input  logic                m_readdatavalid,
   output logic                addr_err,
   output logic                proto_err
);

   logic            cmd_vld;
   logic            accept;
   logic            do_push;
   logic            do_pop;
   logic            fifo_full;
   logic            fifo_empty;
   lane_t           cmd_lane;
   lane_t           ret_lane;
   logic [S_DW-1:0] wdata;
   logic            unused_addr_bits;

   // Byte offset within the 32-bit word plays no part in a word access.
   assign unused_addr_bits = ^s_address[1:0];

   assign cmd_lane = s_address[3:2];
   assign cmd_vld  = m_read | m_write;

   // The single command register can take a new command when empty or when
   // its current one is leaving this cycle. A read also needs a free FIFO
   // slot; the full check ignores a same-cycle pop so the path stays short.
   assign accept        = (s_read | s_write) & (~cmd_vld | ~m_waitrequest)
                          & ~(s_read & fifo_full);
   assign s_waitrequest = (s_read | s_write) & ~accept;

   assign do_push = accept & s_read;
   assign do_pop  = m_readdatavalid & ~fifo_empty;

   assign m_burstcount  = 1'b1;
   assign m_debugaccess = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_wdata_rep
         assign m_writedata[gi*S_DW +: S_DW] = wdata;
      end
   endgenerate

   ocm_lane_fifo #(
      .DEPTH (MAX_PENDING)
   ) u_lane_fifo (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .push      (do_push),
      .push_lane (cmd_lane),
      .pop       (do_pop),
      .pop_lane  (ret_lane),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Command register. Out-of-range addresses are truncated, not blocked.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_address    <= '0;
         m_byteenable <= '0;
         wdata        <= '0;
      end else if (accept) begin
         m_read       <= s_read;
         m_write      <= s_write;
         m_address    <= {s_address[OCM_AW-1:4], 4'h0};
         m_byteenable <= be_shift(s_byteenable, cmd_lane);
         wdata        <= s_writedata;
      end else if (!m_waitrequest) begin
         m_read       <= 1'b0;
         m_write      <= 1'b0;
      end
   end

   // Read return path: narrow the wide beat using the oldest queued lane.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         s_readdatavalid <= 1'b0;
         s_readdata      <= '0;
      end else begin
         s_readdatavalid <= do_pop;
         if (do_pop) begin
            s_readdata <= lane_select(m_readdata, ret_lane);
         end
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         addr_err  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (accept && (s_address[31:OCM_AW] != '0)) addr_err <= 1'b1;
         if (m_readdatavalid && fifo_empty)         proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ocm_avmm_width_adapter.sv
module tb_ocm_avmm_width_adapter;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n;
   logic [31:0]   s_address;
   logic          s_read;
   logic          s_write;
   logic [31:0]   s_writedata;
   logic [3:0]    s_byteenable;
   logic          s_waitrequest;
   logic [31:0]   s_readdata;
   logic          s_readdatavalid;
   logic [17:0]   m_address;
   logic          m_read;
   logic          m_write;
   logic [127:0]  m_writedata;
   logic [15:0]   m_byteenable;
   logic          m_burstcount;
   logic          m_debugaccess;
   logic          m_waitrequest;
   logic [127:0]  m_readdata;
   logic          m_readdatavalid;
   logic          addr_err;
   logic          proto_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_clk = ~clk_clk;

   ocm_avmm_width_adapter #(.MAX_PENDING(8), .OCM_AW(18)) dut (
      .clk_clk         (clk_clk),
      .reset_reset_n   (reset_reset_n),
      .s_address       (s_address),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_byteenable    (m_byteenable),
      .m_burstcount    (m_burstcount),
      .m_debugaccess   (m_debugaccess),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .addr_err        (addr_err),
      .proto_err       (proto_err)
   );

   typedef struct {
      bit           rd;
      logic [31:0]  addr;
      logic [31:0]  wdata;
      logic [3:0]   be;
      logic [127:0] rdata;
      logic [17:0]  exp_maddr;
      logic [15:0]  exp_be;
      logic [31:0]  exp_word;
   } vec_t;

   typedef struct {
      bit           rd;
      logic [17:0]  maddr;
      logic [15:0]  be;
      logic [127:0] wdata;
   } cmd_t;

   vec_t         vecs [6];
   cmd_t         exp_cmd [$];
   logic [1:0]   lane_q [$];
   logic [31:0]  exp_rd [$];
   int           br_pending = 0;
   int           n_rd_acc = 0;
   int           n_rd_ret = 0;
   bit           done = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", nm, act);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   // Wide beat whose word k carries beat number j and lane k.
   function automatic logic [127:0] beat(input int j);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'hA000_0000 + 32'(j*256 + k);
      return r;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, " m_cmd"},  {m_read, m_write}, 2'b00);
      chk({tag, " m_addr"}, m_address, 18'h0);
      chk({tag, " m_wd"},   m_writedata, 128'h0);
      chk({tag, " m_be"},   m_byteenable, 16'h0);
      chk({tag, " s_rdv"},  s_readdatavalid, 1'b0);
      chk({tag, " s_rd"},   s_readdata, 32'h0);
      chk({tag, " burst/dbg"}, {m_burstcount, m_debugaccess}, 2'b10);
      chk({tag, " errs"},   {addr_err, proto_err}, 2'b00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_reset_n   = 1'b0;
      s_address       = '0;
      s_read          = 1'b0;
      s_write         = 1'b0;
      s_writedata     = '0;
      s_byteenable    = '0;
      m_waitrequest   = 1'b0;
      m_readdata      = '0;
      m_readdatavalid = 1'b0;

      vecs[0] = '{0, 32'h0000_0008, 32'hDEADBEEF, 4'hF, 128'h0, 18'h00000, 16'h0F00, 32'h0};
      vecs[1] = '{1, 32'h0000_0014, 32'h0, 4'hF,
                  128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 18'h00010, 16'h00F0, 32'hBBBBBBBB};
      vecs[2] = '{0, 32'h0000_003C, 32'h12345678, 4'h3, 128'h0, 18'h00030, 16'h3000, 32'h0};
      vecs[3] = '{1, 32'h0003_FFF0, 32'h0, 4'hF,
                  128'h44444444_33333333_22222222_11111111, 18'h3FFF0, 16'h000F, 32'h11111111};
      vecs[4] = '{1, 32'h0000_002C, 32'h0, 4'hF,
                  128'h89ABCDEF_01234567_FEDCBA98_76543210, 18'h00020, 16'hF000, 32'h89ABCDEF};
      vecs[5] = '{0, 32'h0000_0104, 32'hA5A55A5A, 4'h9, 128'h0, 18'h00100, 16'h0090, 32'h0};

      repeat (3) tick();
      check_reset_vals("reset");
      reset_reset_n = 1'b1;
      tick();

      // ---- table: single commands (T1, T2 and more) ----
      for (int i = 0; i < 6; i++) begin
         vec_t v;
         v = vecs[i];
         s_read = v.rd; s_write = !v.rd;
         s_address = v.addr; s_writedata = v.wdata; s_byteenable = v.be;
         #1 chk($sformatf("vec%0d s_wait", i), s_waitrequest, 1'b0);
         tick();
         s_read = 1'b0; s_write = 1'b0;
         chk($sformatf("vec%0d m_cmd", i), {m_read, m_write}, {v.rd, !v.rd});
         chk($sformatf("vec%0d m_addr", i), m_address, v.exp_maddr);
         chk($sformatf("vec%0d m_be", i), m_byteenable, v.exp_be);
         if (!v.rd) chk($sformatf("vec%0d m_wd", i), m_writedata, {4{v.wdata}});
         if (v.rd) begin
            m_readdatavalid = 1'b1; m_readdata = v.rdata;
         end
         tick();
         chk($sformatf("vec%0d m_cmd off", i), {m_read, m_write}, 2'b00);
         if (v.rd) begin
            m_readdatavalid = 1'b0;
            chk($sformatf("vec%0d s_rdv", i), s_readdatavalid, 1'b1);
            chk($sformatf("vec%0d s_rdata", i), s_readdata, v.exp_word);
         end
         tick();
         chk($sformatf("vec%0d s_rdv off", i), s_readdatavalid, 1'b0);
      end

      // ---- T3: nine reads with returns withheld ----
      for (int i = 0; i < 9; i++) begin
         s_read = 1'b1; s_byteenable = 4'hF; s_address = 32'h200 + 32'(i*4);
         #1 chk($sformatf("T3 rd%0d s_wait", i), s_waitrequest, (i == 8) ? 1'b1 : 1'b0);
         if (i < 8) tick();
      end
      repeat (3) begin
         tick();
         chk("T3 9th stalled", s_waitrequest, 1'b1);
      end
      m_readdatavalid = 1'b1; m_readdata = beat(0);
      #1 chk("T3 stall in ret cycle", s_waitrequest, 1'b1);
      tick();
      m_readdatavalid = 1'b0;
      chk("T3 ret0 rdv", s_readdatavalid, 1'b1);
      chk("T3 ret0 data", s_readdata, 32'hA000_0000);
      #1 chk("T3 9th released", s_waitrequest, 1'b0);
      tick();
      s_read = 1'b0;
      for (int j = 1; j < 9; j++) begin
         m_readdatavalid = 1'b1; m_readdata = beat(j);
         tick();
         chk($sformatf("T3 ret%0d rdv", j), s_readdatavalid, 1'b1);
         chk($sformatf("T3 ret%0d data", j), s_readdata, 32'hA000_0000 + 32'(j*256 + (j % 4)));
      end
      m_readdatavalid = 1'b0;
      tick();
      chk("T3 drained", s_readdatavalid, 1'b0);

      // ---- T4: bridge stall with a write queued and a read behind ----
      m_waitrequest = 1'b1;
      s_write = 1'b1; s_address = 32'h48; s_writedata = 32'hCAFEF00D; s_byteenable = 4'hF;
      #1 chk("T4 wr accept", s_waitrequest, 1'b0);
      tick();
      s_write = 1'b0; s_read = 1'b1; s_address = 32'h54;
      for (int c = 0; c < 5; c++) begin
         #1 chk($sformatf("T4 c%0d rd stalled", c), s_waitrequest, 1'b1);
         chk($sformatf("T4 c%0d cmd", c), {m_write, m_read, m_address, m_byteenable},
             {1'b1, 1'b0, 18'h40, 16'h0F00});
         chk($sformatf("T4 c%0d wd", c), m_writedata, {4{32'hCAFEF00D}});
         tick();
      end
      m_waitrequest = 1'b0;
      #1 chk("T4 rd released", s_waitrequest, 1'b0);
      tick();
      s_read = 1'b0;
      chk("T4 rd issued", {m_write, m_read, m_address, m_byteenable},
          {1'b0, 1'b1, 18'h50, 16'h00F0});
      m_readdatavalid = 1'b1; m_readdata = beat(7);
      tick();
      m_readdatavalid = 1'b0;
      chk("T4 rd data", {s_readdatavalid, s_readdata}, {1'b1, 32'hA000_0701});
      tick();

      // ---- randomized traffic against a queue-based reference ----
      fork
         begin : master
            for (int n = 0; n < 150; n++) begin
               bit          rd;
               logic [31:0] addr;
               logic [31:0] wd;
               logic [3:0]  be;
               cmd_t        e;
               int          waitc;
               repeat ($urandom_range(0, 2)) tick();
               rd   = ($urandom_range(0, 1) == 1);
               addr = $urandom & 32'h0003_FFFF;
               wd   = $urandom;
               be   = rd ? 4'hF : 4'($urandom_range(1, 15));
               s_read = rd; s_write = !rd;
               s_address = addr; s_writedata = wd; s_byteenable = be;
               waitc = 0;
               @(negedge clk_clk);
               while (s_waitrequest && waitc < 500) begin
                  waitc++;
                  @(negedge clk_clk);
               end
               if (waitc >= 500) chk("rand accept timeout", 1'b1, 1'b0);
               e.rd    = rd;
               e.maddr = 18'(addr & 32'h0003_FFF0);
               e.be    = 16'(32'(be) << (4 * int'(addr[3:2])));
               e.wdata = {4{wd}};
               exp_cmd.push_back(e);
               if (rd) begin
                  lane_q.push_back(addr[3:2]);
                  n_rd_acc++;
               end
               tick();
               s_read = 1'b0; s_write = 1'b0;
            end
            for (int w = 0; w < 400; w++) begin
               if (exp_cmd.size() == 0 && lane_q.size() == 0 && exp_rd.size() == 0
                   && br_pending == 0) break;
               tick();
            end
            chk("rand leftover cmds", exp_cmd.size(), 0);
            chk("rand leftover reads", lane_q.size() + exp_rd.size(), 0);
            chk("rand read count", n_rd_ret, n_rd_acc);
            done = 1;
         end
         begin : bridge
            while (!done) begin
               logic [127:0] d;
               logic [1:0]   l;
               tick();
               if (done) break;
               m_waitrequest = ($urandom_range(0, 3) == 0);
               if (br_pending > 0 && $urandom_range(0, 1) == 1) begin
                  d = {$urandom, $urandom, $urandom, $urandom};
                  m_readdata = d; m_readdatavalid = 1'b1;
                  br_pending--;
                  l = lane_q.pop_front();
                  exp_rd.push_back(d[int'(l)*32 +: 32]);
               end else begin
                  m_readdatavalid = 1'b0;
               end
            end
            m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
         end
         begin : monitor
            while (!done) begin
               cmd_t e;
               @(negedge clk_clk);
               if ((m_read || m_write) && !m_waitrequest) begin
                  if (exp_cmd.size() == 0) chk("rand unexpected m cmd", 1'b1, 1'b0);
                  else begin
                     e = exp_cmd.pop_front();
                     chk("rand m cmd", {m_read, m_write, m_address, m_byteenable},
                         {e.rd, !e.rd, e.maddr, e.be});
                     if (!e.rd) chk("rand m wd", m_writedata, e.wdata);
                     if (m_read) br_pending++;
                  end
               end
               if (s_readdatavalid) begin
                  n_rd_ret++;
                  if (exp_rd.size() == 0) chk("rand unexpected rdv", 1'b1, 1'b0);
                  else chk("rand s_rdata", s_readdata, exp_rd.pop_front());
               end
            end
         end
      join
      tick();
      m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
      chk("rand no errs", {addr_err, proto_err}, 2'b00);

      // ---- T5: spurious return and out-of-range address ----
      m_readdatavalid = 1'b1; m_readdata = beat(3);
      tick();
      m_readdatavalid = 1'b0;
      chk("T5 proto_err", proto_err, 1'b1);
      chk("T5 no rdv", s_readdatavalid, 1'b0);
      s_write = 1'b1; s_address = 32'h0004_0000; s_writedata = 32'h11112222; s_byteenable = 4'hF;
      tick();
      s_write = 1'b0;
      chk("T5 aliased wr", {m_write, m_address, m_byteenable}, {1'b1, 18'h0, 16'h000F});
      chk("T5 addr_err", addr_err, 1'b1);
      tick();

      // ---- T6: reset with three reads pending ----
      for (int i = 0; i < 3; i++) begin
         s_read = 1'b1; s_address = 32'h300 + 32'(i*4); s_byteenable = 4'hF;
         tick();
      end
      s_read = 1'b0;
      reset_reset_n = 1'b0;
      #1 check_reset_vals("T6 reset");
      tick();
      reset_reset_n = 1'b1;
      tick();
      for (int j = 0; j < 3; j++) begin
         m_readdatavalid = 1'b1; m_readdata = beat(20 + j);
         tick();
         chk($sformatf("T6 ret%0d dropped", j), s_readdatavalid, 1'b0);
      end
      m_readdatavalid = 1'b0;
      tick();
      chk("T6 errs", {addr_err, proto_err}, 2'b01);
      chk("T6 no rdv", s_readdatavalid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
